// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_t;

  localparam logic       GRANT_IF = 1'b0;
  localparam logic       GRANT_DM = 1'b1;
  localparam logic [3:0] BE_ALL   = 4'b1111;

  // Access-cycle counter width; bounds MEM_LAT to 1..15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// 2-way round-robin picker: req[0] = fetch, req[1] = data.
// On a tie the side that was not served last wins.
module arb_rr2
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_sel
);

  // Combinational pick; a lone requester always wins.
  always_comb begin
    gnt_valid = |req;
    gnt_sel   = GRANT_IF;
    if (req == 2'b11) begin
      gnt_sel = ~last;
    end else if (req[1]) begin
      gnt_sel = GRANT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch
// and data load/store, with a fixed-latency access sequence.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ARB_IDLE   | waiting; a high req here is a new request, winner latched
//   ARB_ACCESS | mem_en held MEM_LAT cycles; write strobe only on the first
//   ARB_DONE   | one-cycle ack to the winner, memory idle
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [3:0]        dm_be,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_grant
);

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
      $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sel_q;
  logic             we_q;
  logic             gnt_valid, gnt_sel;

  arb_rr2 u_rr (
    .req       ({dm_req, if_req}),
    .last      (last_grant),
    .gnt_valid (gnt_valid),
    .gnt_sel   (gnt_sel)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next state plus the strobes that depend only on the current state.
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (gnt_valid) state_nxt = ARB_ACCESS;
      end
      ARB_ACCESS: begin
        mem_en = 1'b1;
        // Write commits on the first access edge only.
        mem_we = we_q && (cnt == LAT_C);
        if (cnt == ONE_C) state_nxt = ARB_DONE;
      end
      ARB_DONE: begin
        if_ack    = (sel_q == GRANT_IF);
        dm_ack    = (sel_q == GRANT_DM);
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign busy = (state != ARB_IDLE);

  // Operand latch at grant, access counter, and read-data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sel_q      <= GRANT_IF;
      we_q       <= 1'b0;
      last_grant <= GRANT_DM;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt_valid) begin
            sel_q      <= gnt_sel;
            last_grant <= gnt_sel;
            cnt        <= LAT_C;
            if (gnt_sel == GRANT_DM) begin
              we_q      <= dm_we;
              mem_addr  <= dm_addr;
              mem_be    <= dm_be;
              mem_wdata <= dm_wdata;
            end else begin
              we_q     <= 1'b0;
              mem_addr <= if_addr;
              mem_be   <= BE_ALL;
            end
          end
        end
        ARB_ACCESS: begin
          cnt <= cnt - ONE_C;
          if (cnt == ONE_C && !we_q) begin
            if (sel_q == GRANT_DM) dm_rdata <= mem_rdata;
            else                   if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Requester must hold req while its access is in flight.
  property p_req_held;
    @(posedge clk) disable iff (rst)
      (state == ARB_ACCESS) |-> ((sel_q == GRANT_DM) ? dm_req : if_req);
  endproperty
  a_req_held: assert property (p_req_held)
    else $warning("mem_port_arbiter: req dropped before ack");

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline model checked every cycle, plus
// directed transactions with hand-computed expectations.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk, rst;
  logic        if_req, dm_req, dm_we;
  logic [9:0]  if_addr, dm_addr, mem_addr;
  logic [3:0]  dm_be, mem_be;
  logic [31:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
  logic        if_ack, dm_ack, mem_en, mem_we, busy, last_grant;

  logic        if_req_b, dm_req_b, dm_we_b;
  logic [9:0]  if_addr_b, dm_addr_b, mem_addr_b;
  logic [3:0]  dm_be_b, mem_be_b;
  logic [31:0] dm_wdata_b, if_rdata_b, dm_rdata_b, mem_wdata_b, mem_rdata_b;
  logic        if_ack_b, dm_ack_b, mem_en_b, mem_we_b, busy_b, last_grant_b;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .last_grant(last_grant)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(1)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
    .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_be(dm_be_b), .dm_addr(dm_addr_b),
    .dm_wdata(dm_wdata_b), .dm_ack(dm_ack_b), .dm_rdata(dm_rdata_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_be(mem_be_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .last_grant(last_grant_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory seen by the DUT: combinational read, byte-enabled write.
  assign mem_rdata   = mem[mem_addr];
  assign mem_rdata_b = {22'h0, mem_addr_b} ^ 32'h5A5A_0000;

  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_we === 1'b1)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: a grant at edge g gives access cycles g+1..g+LAT,
  // ack in cycle g+LAT+1, and the next grant no earlier than edge g+LAT+2.
  bit          m_active;
  int          m_p;
  logic        m_sel, m_we, m_last;
  logic [9:0]  m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata, m_if_rd, m_dm_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0; m_p = 0; m_last = 1'b1; m_sel = 1'b0; m_we = 1'b0;
      m_addr = '0; m_be = '0; m_wdata = '0; m_if_rd = '0; m_dm_rd = '0;
    end else if (m_active) begin
      if (m_p == 1 && m_we)
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ref_mem[m_addr][8*b +: 8] = m_wdata[8*b +: 8];
      if (m_p == LAT && !m_we) begin
        if (m_sel) m_dm_rd = ref_mem[m_addr];
        else       m_if_rd = ref_mem[m_addr];
      end
      if (m_p == LAT + 1) m_active = 1'b0;
      else                m_p++;
    end else if (if_req || dm_req) begin
      m_sel    = (if_req && dm_req) ? ~m_last : dm_req;
      m_last   = m_sel;
      m_active = 1'b1;
      m_p      = 1;
      if (m_sel) begin
        m_we = dm_we; m_addr = dm_addr; m_be = dm_be; m_wdata = dm_wdata;
      end else begin
        m_we = 1'b0; m_addr = if_addr; m_be = 4'b1111;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("mem_en",     32'(mem_en),     32'(m_active && m_p <= LAT));
      chk("mem_we",     32'(mem_we),     32'(m_active && m_p == 1 && m_we));
      chk("if_ack",     32'(if_ack),     32'(m_active && m_p == LAT + 1 && !m_sel));
      chk("dm_ack",     32'(dm_ack),     32'(m_active && m_p == LAT + 1 && m_sel));
      chk("busy",       32'(busy),       32'(m_active));
      chk("last_grant", 32'(last_grant), 32'(m_last));
      chk("mem_addr",   32'(mem_addr),   32'(m_addr));
      chk("mem_be",     32'(mem_be),     32'(m_be));
      chk("mem_wdata",  mem_wdata,       m_wdata);
      chk("if_rdata",   if_rdata,        m_if_rd);
      chk("dm_rdata",   dm_rdata,        m_dm_rd);
    end
  end

  // Runs one transaction on the LAT=2 instance; cycle k is after k edges
  // from the sampling edge.
  task automatic do_txn(input bit is_dm, input bit we, input logic [3:0] be,
                        input logic [9:0] addr, input logic [31:0] wd,
                        output int ack_cyc, output int en_cnt, output int we_cnt,
                        output logic we_c1, output logic [3:0] be_c1,
                        output logic busy_after);
    if (is_dm) begin
      dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    ack_cyc = -1; en_cnt = 0; we_cnt = 0; we_c1 = 1'b0; be_c1 = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (k == 1) begin we_c1 = mem_we; be_c1 = mem_be; end
      if ((is_dm && dm_ack) || (!is_dm && if_ack)) begin
        ack_cyc = k;
        break;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    @(negedge clk);
    busy_after = busy;
  endtask

  int          ack_c, en_c, we_c;
  logic        we1, bsy;
  logic [3:0]  be1;
  logic [15:0] if_mask, dm_mask;
  logic        lg1, lg5, lg9;

  initial begin
    rst = 1'b0;
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
    if_req_b = 0; if_addr_b = '0; dm_req_b = 0; dm_we_b = 0; dm_be_b = '0; dm_addr_b = '0;
    dm_wdata_b = '0;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     <= 32'hA500_0000 | 32'(i);
      ref_mem[i]  = 32'hA500_0000 | 32'(i);
    end
    mem[1]    <= 32'h2010_0005;
    ref_mem[1] = 32'h2010_0005;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset last_grant", 32'(last_grant), 32'd1);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset if_rdata", if_rdata, 32'd0);

    // IF read of word 1
    do_txn(1'b0, 1'b0, 4'b0000, 10'h001, 32'h0, ack_c, en_c, we_c, we1, be1, bsy);
    chk("if read ack cycle", 32'(ack_c), 32'd3);
    chk("if read mem_en cycles", 32'(en_c), 32'd2);
    chk("if read rdata", if_rdata, 32'h2010_0005);
    chk("if read busy after", 32'(bsy), 32'd0);

    // DM load of word 4, then store, then reload
    do_txn(1'b1, 1'b0, 4'b1111, 10'h004, 32'h0, ack_c, en_c, we_c, we1, be1, bsy);
    chk("dm load ack cycle", 32'(ack_c), 32'd3);
    chk("dm load rdata", dm_rdata, 32'hA500_0004);
    do_txn(1'b1, 1'b1, 4'b0011, 10'h004, 32'hDEAD_BEEF, ack_c, en_c, we_c, we1, be1, bsy);
    chk("store ack cycle", 32'(ack_c), 32'd3);
    chk("store we cycles", 32'(we_c), 32'd1);
    chk("store we in cycle 1", 32'(we1), 32'd1);
    chk("store be in cycle 1", 32'(be1), 32'h3);
    chk("store dm_rdata kept", dm_rdata, 32'hA500_0004);
    do_txn(1'b1, 1'b0, 4'b1111, 10'h004, 32'h0, ack_c, en_c, we_c, we1, be1, bsy);
    chk("reload after store", dm_rdata, 32'hA500_BEEF);

    // Asynchronous reset between edges during an IF access
    if_req = 1'b1; if_addr = 10'h001;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst mem_en", 32'(mem_en), 32'd0);
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst if_ack", 32'(if_ack), 32'd0);
    chk("async rst if_rdata", if_rdata, 32'd0);
    chk("async rst dm_rdata", dm_rdata, 32'd0);
    chk("async rst last_grant", 32'(last_grant), 32'd1);
    chk("async rst mem_addr", 32'(mem_addr), 32'd0);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // DM read cut by reset in its second access cycle
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h008; dm_be = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("cut read mem_en", 32'(mem_en), 32'd0);
    chk("cut read dm_ack", 32'(dm_ack), 32'd0);
    chk("cut read dm_rdata", dm_rdata, 32'd0);
    dm_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_txn(1'b1, 1'b0, 4'b1111, 10'h008, 32'h0, ack_c, en_c, we_c, we1, be1, bsy);
    chk("fresh read ack cycle", 32'(ack_c), 32'd3);
    chk("fresh read rdata", dm_rdata, 32'hA500_0008);

    // Both requesters held from reset: strict alternation
    rst = 1'b1;
    if_req = 1'b1; if_addr = 10'h002;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h003;
    @(negedge clk);
    rst = 1'b0;
    if_mask = '0; dm_mask = '0; lg1 = 1'b1; lg5 = 1'b0; lg9 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if_mask[k] = if_ack;
      dm_mask[k] = dm_ack;
      if (k == 1) lg1 = last_grant;
      if (k == 5) lg5 = last_grant;
      if (k == 9) lg9 = last_grant;
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("alternate if acks", 32'(if_mask), 32'h0808);
    chk("alternate dm acks", 32'(dm_mask), 32'h0080);
    chk("last_grant after IF", 32'(lg1), 32'd0);
    chk("last_grant after DM", 32'(lg5), 32'd1);
    chk("last_grant after IF again", 32'(lg9), 32'd0);
    chk("alternate dm_rdata", dm_rdata, 32'hA500_0003);
    @(negedge clk);
    chk("alternate idle after", 32'(busy), 32'd0);

    // MEM_LAT=1 instance, IF read
    if_req_b = 1'b1; if_addr_b = 10'h00F;
    ack_c = -1; en_c = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_en_b) en_c++;
      if (if_ack_b) begin ack_c = k; break; end
    end
    if_req_b = 1'b0;
    chk("lat1 ack cycle", 32'(ack_c), 32'd2);
    chk("lat1 mem_en cycles", 32'(en_c), 32'd1);
    chk("lat1 rdata", if_rdata_b, 32'h5A5A_000F);
    @(negedge clk);
    chk("lat1 idle after", 32'(busy_b), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
